clk_div_multi: RTL

- Multi-channel, run-time programmable clock-enable/divider generator; next generation of the fixed-parameter single-channel divider.
- Each channel divides the system clock by a programmable ratio with programmable high time and phase offset.
- New settings are shadowed and committed glitch-free at the channel's period boundary.
- Feeds gate-time, reference-tick and strobe generation for the frequency-measurement datapath.

---
 rtl/clk_div_multi.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider with shadowed, glitch-free config commit.
// Each channel counts 0..act_div-1 and drives clk_div = (cnt < act_duty) from registered state.
module clk_div_multi #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned DEF_DIV  = 1000,
    parameter int unsigned DEF_DUTY = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    align,
    input  logic [N_CH-1:0]         load,
    input  logic [N_CH*CNT_W-1:0]   div_n,
    input  logic [N_CH*CNT_W-1:0]   duty_n,
    input  logic [N_CH*CNT_W-1:0]   phase_n,
    output logic [N_CH-1:0]         clk_div,
    output logic [N_CH*CNT_W-1:0]   cnt,
    output logic [N_CH-1:0]         wrap,
    output logic [N_CH-1:0]         cfg_err
);

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_act_div;
        logic [CNT_W-1:0] r_act_duty;
        logic [CNT_W-1:0] r_act_phase;
        logic [CNT_W-1:0] r_pend_div;
        logic [CNT_W-1:0] r_pend_duty;
        logic [CNT_W-1:0] r_pend_phase;
        logic             r_pend;
        logic [CNT_W-1:0] r_cnt;
        logic             r_clk_div;
        logic             r_wrap;
        logic             r_cfg_err;

        logic [CNT_W-1:0] w_in_div;
        logic [CNT_W-1:0] w_in_duty;
        logic [CNT_W-1:0] w_in_phase;
        logic [CNT_W-1:0] w_src_div;
        logic [CNT_W-1:0] w_src_duty;
        logic [CNT_W-1:0] w_src_phase;
        logic [CNT_W-1:0] w_leg_div;
        logic [CNT_W-1:0] w_leg_phase;
        logic             w_leg_err;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             w_at_end;
        logic             w_commit;

        assign w_in_div   = div_n[g*CNT_W +: CNT_W];
        assign w_in_duty  = duty_n[g*CNT_W +: CNT_W];
        assign w_in_phase = phase_n[g*CNT_W +: CNT_W];

        // Commit source (a load coinciding with the wrap bypasses the shadow) and its legalisation.
        always_comb begin
            w_src_div   = r_pend_div;
            w_src_duty  = r_pend_duty;
            w_src_phase = r_pend_phase;
            if (load[g]) begin
                w_src_div   = w_in_div;
                w_src_duty  = w_in_duty;
                w_src_phase = w_in_phase;
            end
            w_leg_div   = (w_src_div < MIN_DIV) ? MIN_DIV : w_src_div;
            w_leg_phase = (w_src_phase >= w_leg_div) ? '0 : w_src_phase;
            w_leg_err   = (w_src_div < MIN_DIV) || (w_src_phase >= w_leg_div);
            w_cnt_inc   = r_cnt + CNT_W'(1);
            w_at_end    = (r_cnt >= (r_act_div - CNT_W'(1)));
            w_commit    = en && !align && w_at_end && (load[g] || r_pend);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_act_div    <= CNT_W'(DEF_DIV);
                r_act_duty   <= CNT_W'(DEF_DUTY);
                r_act_phase  <= '0;
                r_pend_div   <= '0;
                r_pend_duty  <= '0;
                r_pend_phase <= '0;
                r_pend       <= 1'b0;
                r_cnt        <= '0;
                r_clk_div    <= (DEF_DUTY != 0);
                r_wrap       <= 1'b0;
                r_cfg_err    <= 1'b0;
            end else begin
                r_wrap    <= 1'b0;
                r_cfg_err <= 1'b0;

                // Shadow capture; skipped when the same load commits directly.
                if (load[g] && !w_commit) begin
                    r_pend_div   <= w_in_div;
                    r_pend_duty  <= w_in_duty;
                    r_pend_phase <= w_in_phase;
                    r_pend       <= 1'b1;
                end

                if (align) begin
                    r_cnt     <= r_act_phase;
                    r_clk_div <= (r_act_phase < r_act_duty);
                end else if (en) begin
                    if (w_at_end) begin
                        r_cnt  <= '0;
                        r_wrap <= 1'b1;
                        if (w_commit) begin
                            r_act_div   <= w_leg_div;
                            r_act_duty  <= w_src_duty;
                            r_act_phase <= w_leg_phase;
                            r_pend      <= 1'b0;
                            r_cfg_err   <= w_leg_err;
                            r_clk_div   <= (w_src_duty != '0);
                        end else begin
                            r_clk_div   <= (r_act_duty != '0);
                        end
                    end else begin
                        r_cnt     <= w_cnt_inc;
                        r_clk_div <= (w_cnt_inc < r_act_duty);
                    end
                end
            end
        end

        assign cnt[g*CNT_W +: CNT_W] = r_cnt;
        assign clk_div[g]            = r_clk_div;
        assign wrap[g]               = r_wrap;
        assign cfg_err[g]            = r_cfg_err;
    end

endmodule
